// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared widths, entry layout and label helpers for the reorder buffer
package reorder_buffer_pkg;

  localparam int ROB_SIZE     = 8;
  localparam int ROB_ID_WIDTH = 3;
  localparam int LAB_WIDTH    = ROB_ID_WIDTH + 1;
  localparam int VAL_WIDTH    = 32;
  localparam int ADDR_WIDTH   = 32;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [4:0]            rd;
    logic [VAL_WIDTH-1:0]  val;
    logic                  is_branch;
    logic                  pred_taken;
    logic                  act_jump;
    logic [ADDR_WIDTH-1:0] next_pc;
  } rob_entry_t;

  // Label 0 means "no dependency"; entry i is known outside as label i+1.
  function automatic logic lab_valid(input logic [LAB_WIDTH-1:0] lab);
    return (lab != '0) && (lab <= LAB_WIDTH'(ROB_SIZE));
  endfunction

  function automatic logic [ROB_ID_WIDTH-1:0] lab2idx(input logic [LAB_WIDTH-1:0] lab);
    logic [LAB_WIDTH-1:0] t;
    t = lab - LAB_WIDTH'(1);
    return t[ROB_ID_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with dual CDB writeback, operand forwarding and mispredict flush
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  dec2rob_en,
  input  logic [4:0]            dec_rd,
  input  logic                  dec_is_branch,
  input  logic                  dec_pred_taken,
  output logic [LAB_WIDTH-1:0]  newTag,
  output logic                  isFull,
  input  logic [LAB_WIDTH-1:0]  query_lab1,
  input  logic [LAB_WIDTH-1:0]  query_lab2,
  output logic                  ready1,
  output logic                  ready2,
  output logic [VAL_WIDTH-1:0]  res1,
  output logic [VAL_WIDTH-1:0]  res2,
  input  logic                  rs_cdb_en,
  input  logic [LAB_WIDTH-1:0]  rs_cdb2lab,
  input  logic [VAL_WIDTH-1:0]  rs_cdb2val,
  input  logic                  rs_cdb_jump,
  input  logic [ADDR_WIDTH-1:0] rs_cdb_pc,
  input  logic                  lsb_cdb_en,
  input  logic [LAB_WIDTH-1:0]  lsb_cdb2lab,
  input  logic [VAL_WIDTH-1:0]  lsb_cdb2val,
  output logic                  commit_en,
  output logic [4:0]            commit_rd,
  output logic [VAL_WIDTH-1:0]  commit_val,
  output logic [LAB_WIDTH-1:0]  commit_lab,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc
);

  logic [ROB_ID_WIDTH-1:0] head, tail;
  logic [ROB_ID_WIDTH:0]   count;
  rob_entry_t              rob [ROB_SIZE];

  rob_entry_t head_e;
  logic       issue_fire, commit_fire, mispredict, rs_hit, lsb_hit;

  assign isFull = (count == (ROB_ID_WIDTH+1)'(ROB_SIZE));
  assign newTag = LAB_WIDTH'(tail) + LAB_WIDTH'(1);

  assign head_e      = rob[head];
  assign issue_fire  = dec2rob_en && !isFull && !flush;
  assign commit_fire = head_e.busy && head_e.ready;
  assign mispredict  = commit_fire && head_e.is_branch && (head_e.act_jump != head_e.pred_taken);
  assign rs_hit      = rs_cdb_en && lab_valid(rs_cdb2lab) && rob[lab2idx(rs_cdb2lab)].busy;
  assign lsb_hit     = lsb_cdb_en && lab_valid(lsb_cdb2lab) && rob[lab2idx(lsb_cdb2lab)].busy;

  // Result is {ready, value}; a stored value wins, then same-cycle rs CDB, then lsb CDB.
  function automatic logic [VAL_WIDTH:0] do_query(input logic [LAB_WIDTH-1:0] lab);
    rob_entry_t e;
    e = rob[lab2idx(lab)];
    if (!lab_valid(lab))                       return '0;
    if (e.busy && e.ready)                     return {1'b1, e.val};
    if (rs_cdb_en && (rs_cdb2lab == lab))      return {1'b1, rs_cdb2val};
    if (lsb_cdb_en && (lsb_cdb2lab == lab))    return {1'b1, lsb_cdb2val};
    return '0;
  endfunction

  always_comb begin
    {ready1, res1} = do_query(query_lab1);
    {ready2, res2} = do_query(query_lab2);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      commit_en  <= 1'b0;
      commit_rd  <= '0;
      commit_val <= '0;
      commit_lab <= '0;
      flush      <= 1'b0;
      flush_pc   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) rob[i] <= '0;
    end else if (!rdy_in) begin
      commit_en <= 1'b0;
      flush     <= 1'b0;
    end else begin
      commit_en <= commit_fire;
      flush     <= mispredict;
      if (commit_fire) begin
        commit_rd  <= head_e.rd;
        commit_val <= head_e.val;
        commit_lab <= LAB_WIDTH'(head) + LAB_WIDTH'(1);
      end
      if (mispredict) begin
        // Everything younger than the branch is wrong-path: drop it and this cycle's issue/writeback.
        flush_pc <= head_e.next_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          rob[i].busy  <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else begin
        if (rs_hit) begin
          rob[lab2idx(rs_cdb2lab)].ready    <= 1'b1;
          rob[lab2idx(rs_cdb2lab)].val      <= rs_cdb2val;
          rob[lab2idx(rs_cdb2lab)].act_jump <= rs_cdb_jump;
          rob[lab2idx(rs_cdb2lab)].next_pc  <= rs_cdb_pc;
        end
        if (lsb_hit) begin
          rob[lab2idx(lsb_cdb2lab)].ready <= 1'b1;
          rob[lab2idx(lsb_cdb2lab)].val   <= lsb_cdb2val;
        end
        if (issue_fire) begin
          rob[tail].busy       <= 1'b1;
          rob[tail].ready      <= 1'b0;
          rob[tail].rd         <= dec_rd;
          rob[tail].is_branch  <= dec_is_branch;
          rob[tail].pred_taken <= dec_pred_taken;
          rob[tail].act_jump   <= 1'b0;
          tail                 <= tail + ROB_ID_WIDTH'(1);
        end
        if (commit_fire) begin
          rob[head].busy  <= 1'b0;
          rob[head].ready <= 1'b0;
          head            <= head + ROB_ID_WIDTH'(1);
        end
        count <= count + (ROB_ID_WIDTH+1)'(issue_fire) - (ROB_ID_WIDTH+1)'(commit_fire);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_in, rdy_in;
  logic                  dec2rob_en, dec_is_branch, dec_pred_taken;
  logic [4:0]            dec_rd;
  logic [LAB_WIDTH-1:0]  newTag;
  logic                  isFull;
  logic [LAB_WIDTH-1:0]  query_lab1, query_lab2;
  logic                  ready1, ready2;
  logic [VAL_WIDTH-1:0]  res1, res2;
  logic                  rs_cdb_en, rs_cdb_jump;
  logic [LAB_WIDTH-1:0]  rs_cdb2lab;
  logic [VAL_WIDTH-1:0]  rs_cdb2val;
  logic [ADDR_WIDTH-1:0] rs_cdb_pc;
  logic                  lsb_cdb_en;
  logic [LAB_WIDTH-1:0]  lsb_cdb2lab;
  logic [VAL_WIDTH-1:0]  lsb_cdb2val;
  logic                  commit_en;
  logic [4:0]            commit_rd;
  logic [VAL_WIDTH-1:0]  commit_val;
  logic [LAB_WIDTH-1:0]  commit_lab;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_pc;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec2rob_en(dec2rob_en), .dec_rd(dec_rd), .dec_is_branch(dec_is_branch),
    .dec_pred_taken(dec_pred_taken), .newTag(newTag), .isFull(isFull),
    .query_lab1(query_lab1), .query_lab2(query_lab2), .ready1(ready1), .ready2(ready2),
    .res1(res1), .res2(res2),
    .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
    .rs_cdb_jump(rs_cdb_jump), .rs_cdb_pc(rs_cdb_pc),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab), .lsb_cdb2val(lsb_cdb2val),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_lab(commit_lab), .flush(flush), .flush_pc(flush_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec2rob_en = 0; dec_rd = '0; dec_is_branch = 0; dec_pred_taken = 0;
    query_lab1 = '0; query_lab2 = '0;
    rs_cdb_en = 0; rs_cdb2lab = '0; rs_cdb2val = '0; rs_cdb_jump = 0; rs_cdb_pc = '0;
    lsb_cdb_en = 0; lsb_cdb2lab = '0; lsb_cdb2val = '0;
  endtask

  task automatic rs_wb(input int lab, input int val, input logic jump, input int pc);
    rs_cdb_en = 1; rs_cdb2lab = 4'(lab); rs_cdb2val = 32'(val); rs_cdb_jump = jump; rs_cdb_pc = 32'(pc);
  endtask

  task automatic lsb_wb(input int lab, input int val);
    lsb_cdb_en = 1; lsb_cdb2lab = 4'(lab); lsb_cdb2val = 32'(val);
  endtask

  task automatic expect_commit(input string tag, input int rd, input int val, input int lab);
    check({tag, "_en"},  commit_en, 1);
    check({tag, "_rd"},  commit_rd, rd);
    check({tag, "_val"}, commit_val, val);
    check({tag, "_lab"}, commit_lab, lab);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_in = 0; rdy_in = 1;
    tick(); tick();
    check("rst_commit_en", commit_en, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_commit_lab", commit_lab, 0);
    check("rst_isfull", isFull, 0);
    check("rst_newtag", newTag, 1);
    check("rst_count", dut.count, 0);
    rst_in = 1;
    tick();

    // three issues, then fill to eight
    for (int i = 0; i < 8; i++) begin
      dec2rob_en = 1; dec_rd = 5'(i + 1);
      check("issue_tag", newTag, i + 1);
      tick();
      if (i == 2) begin
        dec2rob_en = 0;
        check("count_after_3", dut.count, 3);
        check("isfull_after_3", isFull, 0);
      end
    end
    dec2rob_en = 0;
    check("isfull_after_8", isFull, 1);
    dec2rob_en = 1; dec_rd = 5'd9;
    tick();
    dec2rob_en = 0;
    check("full_issue_ignored", dut.count, 8);

    // writeback to oldest, commit one cycle later
    lsb_wb(1, 'h5);
    tick();
    idle();
    check("commit_not_early", commit_en, 0);
    tick();
    expect_commit("commit1", 1, 'h5, 1);
    tick();
    check("commit_pulse_ends", commit_en, 0);

    // out-of-order writeback, in-order retirement
    rs_wb(3, 'hA, 0, 0);
    tick();
    idle();
    check("ooo_hold", commit_en, 0);
    lsb_wb(2, 'hB);
    tick();
    idle();
    check("ooo_hold2", commit_en, 0);
    tick();
    expect_commit("ooo_lab2", 2, 'hB, 2);
    tick();
    expect_commit("ooo_lab3", 3, 'hA, 3);

    // both CDBs in the same cycle
    rs_wb(5, 'h55, 0, 0);
    lsb_wb(4, 'h44);
    tick();
    idle();
    tick();
    expect_commit("dual_lab4", 4, 'h44, 4);
    tick();
    expect_commit("dual_lab5", 5, 'h55, 5);
    check("count_after_dual", dut.count, 3);

    // operand query with same-cycle forwarding
    rs_wb(7, 'h77, 0, 0);
    query_lab1 = 4'd7; query_lab2 = 4'd6;
    #1;
    check("fwd_ready1", ready1, 1);
    check("fwd_res1", res1, 'h77);
    check("pend_ready2", ready2, 0);
    check("pend_res2", res2, 0);
    tick();
    rs_cdb_en = 0;
    #1;
    check("stored_ready1", ready1, 1);
    check("stored_res1", res1, 'h77);
    query_lab1 = '0;
    #1;
    check("lab0_ready1", ready1, 0);
    idle();
    rs_wb(6, 'h66, 0, 0);
    lsb_wb(8, 'h88);
    tick();
    idle();
    tick();
    expect_commit("drain_lab6", 6, 'h66, 6);
    tick();
    expect_commit("drain_lab7", 7, 'h77, 7);
    tick();
    expect_commit("drain_lab8", 8, 'h88, 8);
    check("drain_count", dut.count, 0);
    check("drain_newtag", newTag, 1);

    // mispredicted branch flushes younger work
    dec2rob_en = 1; dec_rd = 5'd5; dec_is_branch = 1; dec_pred_taken = 0;
    tick();
    dec_rd = 5'd6; dec_is_branch = 0;
    tick();
    idle();
    rs_wb(1, 0, 1, 'h100);
    tick();
    idle();
    tick();
    expect_commit("mispred", 5, 0, 1);
    check("mispred_flush", flush, 1);
    check("mispred_flush_pc", flush_pc, 'h100);
    check("mispred_count", dut.count, 0);
    check("mispred_newtag", newTag, 1);
    dec2rob_en = 1; dec_rd = 5'd7;
    tick();
    idle();
    check("flush_pulse_ends", flush, 0);
    check("flush_issue_blocked", dut.count, 0);

    // correctly predicted branch, rd=0 passed through
    dec2rob_en = 1; dec_rd = 5'd0; dec_is_branch = 1; dec_pred_taken = 1;
    check("cp_newtag", newTag, 1);
    tick();
    idle();
    rs_wb(1, 'h9, 1, 'h200);
    tick();
    idle();
    tick();
    expect_commit("cp_commit", 0, 'h9, 1);
    check("cp_no_flush", flush, 0);

    // reset mid-operation
    dec2rob_en = 1; dec_rd = 5'd3;
    tick();
    idle();
    check("pre_rst_count", dut.count, 1);
    rst_in = 0;
    #1;
    check("midrst_count", dut.count, 0);
    check("midrst_newtag", newTag, 1);
    check("midrst_commit_en", commit_en, 0);
    tick();
    rst_in = 1;
    tick();

    // wrap-around with an rdy_in stall mid-stream
    for (int i = 0; i < 10; i++) begin
      int tag;
      tag = (i % 8) + 1;
      dec2rob_en = 1; dec_rd = 5'(i + 1);
      check("wrap_tag", newTag, tag);
      tick();
      idle();
      lsb_wb(tag, 'h100 + i);
      tick();
      idle();
      if (i == 4) begin
        rdy_in = 0;
        tick();
        check("stall_no_commit1", commit_en, 0);
        tick();
        check("stall_no_commit2", commit_en, 0);
        check("stall_count", dut.count, 1);
        rdy_in = 1;
      end
      tick();
      expect_commit("wrap_commit", i + 1, 'h100 + i, tag);
    end
    check("wrap_final_count", dut.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: ROB_SIZE, 8, entry count; ROB_ID_WIDTH, 3, log2(ROB_SIZE); labels SHALL be ROB_ID_WIDTH+1 bits, label 0 = "no dependency", entry i carries label i+1.
REQ-002 One clock; reset is asynchronous and active-low: clk input 1, system clock; rst_in input 1, asynchronous active-low reset.
REQ-003 rdy_in input 1, global enable; low freezes all state.
REQ-004 dec2rob_en input 1, issue request; dec_rd input 5, destination register; dec_is_branch input 1, conditional branch; dec_pred_taken input 1, predictor outcome.
REQ-005 newTag output ROB_ID_WIDTH+1, label allocated to current issue; isFull output 1, no free entry.
REQ-006 query_lab1/query_lab2 input ROB_ID_WIDTH+1, operand labels from regFile; ready1/ready2 output 1; res1/res2 output VAL_WIDTH, operand values.
REQ-007 rs_cdb_en input 1; rs_cdb2lab input ROB_ID_WIDTH+1; rs_cdb2val input VAL_WIDTH; rs_cdb_jump input 1, actual taken; rs_cdb_pc input ADDR_WIDTH, correct next PC.
REQ-008 lsb_cdb_en input 1; lsb_cdb2lab input ROB_ID_WIDTH+1; lsb_cdb2val input VAL_WIDTH.
REQ-009 commit_en output 1; commit_rd output 5; commit_val output VAL_WIDTH; commit_lab output ROB_ID_WIDTH+1, label retired.
REQ-010 flush output 1, mispredict flush; flush_pc output ADDR_WIDTH, redirect PC.

Function
REQ-011 Storage SHALL be a circular buffer with head, tail (ROB_ID_WIDTH bits, wrap SIZE-1 -> 0) and count (0..SIZE); per entry: busy, ready, rd, val, is_branch, pred_taken, act_jump, next_pc.
REQ-012 isFull = (count == ROB_SIZE), combinational; newTag = tail+1, combinational.
REQ-013 Issue: on edge with rdy_in & dec2rob_en & !isFull & !flush, entry[tail] <- busy=1, ready=0, fields from dec_*; tail advances; count +1.
REQ-014 Issue while isFull SHALL be ignored, even if a commit occurs in the same cycle.
REQ-015 Writeback: each enabled CDB with nonzero label matching a busy entry sets ready=1, val=cdb value; rs CDB also stores act_jump, next_pc; both CDBs SHALL be accepted in one cycle (distinct labels).
REQ-016 CDB labels that are 0 or match non-busy entries SHALL be ignored.
REQ-017 Query (combinational): label 0 -> ready=0, res=0; matching entry ready -> ready=1, res=val; else same-cycle CDB match -> ready=1, res=CDB value (rs CDB priority); else ready=0, res=0.
REQ-018 Commit: on edge with rdy_in, head busy & ready -> registered commit_en=1, commit_rd, commit_val, commit_lab=head+1 for exactly one cycle; entry freed; head advances; count -1.
REQ-019 Latency: CDB write at edge N -> commit_en high after edge N+1 earliest; at most one commit per cycle.
REQ-020 Simultaneous issue and commit SHALL leave count unchanged.
REQ-021 Mispredict: committing branch with act_jump != pred_taken -> flush=1, flush_pc=next_pc for one cycle, alongside commit_en=1 (commit_rd as stored).
REQ-022 Flush cycle: all busy cleared, head=tail=0, count=0; same-cycle issue and CDB writes discarded.
REQ-023 Correctly predicted branch SHALL commit with flush=0.
REQ-024 rdy_in low: no state change; commit_en and flush driven 0.
REQ-025 commit_rd 0 SHALL be passed through unchanged; regFile discards it.

Reset
REQ-026 rst_in low SHALL immediately clear head, tail, count, all busy/ready, commit_en=0, commit_rd=0, commit_val=0, commit_lab=0, flush=0, flush_pc=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries; first issue after release receives newTag=1.

Structure
REQ-028 ROB_SIZE, ROB_ID_WIDTH, VAL_WIDTH, ADDR_WIDTH, OP_WIDTH SHALL reside in shared util.v.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 Reset, issue 3 (rd=1,2,3) -> newTag 1,2,3; count=3; isFull=0.
REQ-031 Issue 8 -> isFull=1; 9th issue ignored; lsb CDB lab=1 val=0x5 -> next cycle commit_en, rd as issued, val=0x5, lab=1.
REQ-032 CDB out of order: lab=2 val=0xA then lab=1 val=0xB -> commits lab1(0xB) then lab2(0xA) in consecutive cycles.
REQ-033 Query lab=3 while rs CDB broadcasts lab=3 val=0x77 same cycle -> ready1=1, res1=0x77.
REQ-034 Branch pred_taken=0, rs CDB jump=1 pc=0x100 -> commit cycle flush=1, flush_pc=0x100; following cycle count=0, newTag=1.
REQ-035 Wrap: issue/commit 10 entries sequentially -> tags 1..8,1,2; rdy_in low 2 cycles mid-stream -> no commit, state unchanged.
